ddls_lockstep_delay: RTL

Parametrised delay-line block for the dual-core delayed-lockstep (DDLS) subsystem. It carries NCH single-bit control channels (core resetb, RISC-V clock enable, stop-control, …) to the primary core with one register of latency and to the secondary core with a runtime-selectable extra delay of 0..DEPTH-1 cycles. Delay changes go through a valid/ready handshake. On an increase the block stretches the secondary stream so that no sample is replayed or skipped; on a decrease it flags the skipped samples. It sits between the clock/reset controller and the two core wrappers.

---
 rtl/ddls_pkg.sv | 5 +
 rtl/ddls_tap_line.sv | 40 ++++
 rtl/ddls_lockstep_delay.sv | 95 +++++++++
 3 files changed

// File: rtl/ddls_pkg.sv
// ddls_pkg: shared FSM state type and limits for the delayed-lockstep delay line
package ddls_pkg;
  localparam int DDLS_MAX_DEPTH = 64;
  typedef enum logic {IDLE, HOLD} ddls_state_e;
endpackage

// File: rtl/ddls_tap_line.sv
// ddls_tap_line: one channel's shift register, synchronous clear and secondary tap mux
// Ports: in_i sample in, clr_i sync clear, hold_i freeze secondary, sel_i tap select,
//        pri_o 1-cycle delayed sample, sec_o (1+sel_i)-cycle delayed sample
module ddls_tap_line
  import ddls_pkg::*;
#(
  parameter int   DEPTH   = 8,
  parameter int   SELW    = $clog2(DEPTH),
  parameter logic RST_BIT = 1'b0
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            in_i,
  input  logic            clr_i,
  input  logic            hold_i,
  input  logic [SELW-1:0] sel_i,
  output logic            pri_o,
  output logic            sec_o
);
  logic [DEPTH-2:0] pipe_q, pipe_d;
  logic             sec_q, sec_d;
  logic [DEPTH-1:0] taps;
  // taps[0] is the live input, taps[k] is the input delayed k cycles
  assign taps = {pipe_q, in_i};
  always_comb begin
    pipe_d = clr_i ? {(DEPTH-1){RST_BIT}} : taps[DEPTH-2:0];
    sec_d  = clr_i ? RST_BIT : hold_i ? sec_q : taps[sel_i];
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pipe_q <= {(DEPTH-1){RST_BIT}};
      sec_q  <= RST_BIT;
    end else begin
      pipe_q <= pipe_d;
      sec_q  <= sec_d;
    end
  end
  assign pri_o = pipe_q[0];
  assign sec_o = sec_q;
endmodule

// File: rtl/ddls_lockstep_delay.sv
// ddls_lockstep_delay: NCH control channels to primary (1 cycle) and secondary (1+delay_cur cycles)
// Ports: chan_in/chan_clr channel data and clears, primary_out/secondary_out delayed copies,
//        delay_req/_valid/_ready delay-change handshake, delay_cur applied delay,
//        delay_skip pulse on a decrease, delay_err pulse on an out-of-range request
module ddls_lockstep_delay
  import ddls_pkg::*;
#(
  parameter int             NCH           = 2,
  parameter int             DEPTH         = 8,
  parameter int             SELW          = $clog2(DEPTH),
  parameter logic [NCH-1:0] RST_VAL       = '0,
  parameter int             DEFAULT_DELAY = 1
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [NCH-1:0]  chan_in,
  input  logic [NCH-1:0]  chan_clr,
  output logic [NCH-1:0]  primary_out,
  output logic [NCH-1:0]  secondary_out,
  input  logic [SELW-1:0] delay_req,
  input  logic            delay_req_valid,
  output logic            delay_req_ready,
  output logic [SELW-1:0] delay_cur,
  output logic            delay_skip,
  output logic            delay_err
);
  ddls_state_e     state_q, state_d;
  logic [SELW-1:0] cur_q, cur_d, tgt_q, tgt_d, cnt_q, cnt_d;
  logic            skip_q, skip_d, err_q, err_d;
  // An increase freezes the secondary stream for the size of the step so the
  // longer delay is reached without replaying or skipping any sample.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    skip_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == HOLD) begin
      cnt_d = cnt_q - SELW'(1);
      if (cnt_q == SELW'(1)) begin
        state_d = IDLE;
        cur_d   = tgt_q;
      end
    end else if (delay_req_valid) begin
      if (32'(delay_req) >= DEPTH) begin
        err_d = 1'b1;
      end else if (delay_req > cur_q) begin
        state_d = HOLD;
        tgt_d   = delay_req;
        cnt_d   = delay_req - cur_q;
      end else if (delay_req < cur_q) begin
        cur_d  = delay_req;
        skip_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cur_q   <= SELW'(DEFAULT_DELAY);
      tgt_q   <= SELW'(DEFAULT_DELAY);
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ddls_tap_line #(
      .DEPTH  (DEPTH),
      .SELW   (SELW),
      .RST_BIT(RST_VAL[c])
    ) u_tap (
      .clk   (clk),
      .resetb(resetb),
      .in_i  (chan_in[c]),
      .clr_i (chan_clr[c]),
      .hold_i(state_q == HOLD),
      .sel_i (cur_q),
      .pri_o (primary_out[c]),
      .sec_o (secondary_out[c])
    );
  end
  assign delay_req_ready = (state_q == IDLE);
  assign delay_cur       = cur_q;
  assign delay_skip      = skip_q;
  assign delay_err       = err_q;
endmodule
